// File: rtl/tank_pkg.sv
// Shared constants for the tank keyboard path: set-2 scan codes, the ASCII
// key codes used by the direction decoder, and the receiver/decoder state types.
package tank_pkg;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_J     = 8'h3B;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] ASCII_NONE = 8'h00;
    localparam logic [7:0] ASCII_A    = 8'h61;
    localparam logic [7:0] ASCII_D    = 8'h64;
    localparam logic [7:0] ASCII_W    = 8'h77;
    localparam logic [7:0] ASCII_S    = 8'h73;
    localparam logic [7:0] ASCII_J    = 8'h6A;

    typedef enum logic [1:0] {
        DEC_NORM,
        DEC_BRK,
        DEC_EXT,
        DEC_EXT_BRK
    } dec_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Game keys only; anything else maps to ASCII_NONE and is ignored.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
        logic [7:0] result;
        case (code)
            SC_A:    result = ASCII_A;
            SC_D:    result = ASCII_D;
            SC_W:    result = ASCII_W;
            SC_S:    result = ASCII_S;
            SC_J:    result = ASCII_J;
            default: result = ASCII_NONE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx.sv
// PS/2 serial receiver: input synchronizers, falling-edge detect, 11-bit frame
// FSM with odd-parity/stop checking, and an inactivity timeout for partial frames.
module ps2_rx
    import tank_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int             CW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TIMEOUT_MAX = CW'(TIMEOUT_CYCLES);

    logic          clk_sync1_reg, clk_sync2_reg, clk_sync3_reg;
    logic          data_sync1_reg, data_sync2_reg;
    logic          fall;
    logic          data_bit;

    rx_state_t     state_reg, state_next;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt_reg;
    logic          parity_reg;
    logic [CW-1:0] timeout_cnt_reg;
    logic          timeout_hit;
    logic          frame_ok;
    logic          valid_next, err_next;
    logic          valid_reg, err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync1_reg  <= 1'b1;
            clk_sync2_reg  <= 1'b1;
            clk_sync3_reg  <= 1'b1;
            data_sync1_reg <= 1'b1;
            data_sync2_reg <= 1'b1;
        end else begin
            clk_sync1_reg  <= ps2_clk;
            clk_sync2_reg  <= clk_sync1_reg;
            clk_sync3_reg  <= clk_sync2_reg;
            data_sync1_reg <= ps2_data;
            data_sync2_reg <= data_sync1_reg;
        end
    end

    assign fall     = !clk_sync2_reg && clk_sync3_reg;
    assign data_bit = data_sync2_reg;

    // An edge arriving on the very cycle the counter saturates still counts as activity.
    assign timeout_hit = (state_reg != RX_IDLE) && !fall && (timeout_cnt_reg == TIMEOUT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RX_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (timeout_hit) begin
            state_next = RX_IDLE;
        end else if (fall) begin
            case (state_reg)
                RX_IDLE:   if (!data_bit) state_next = RX_DATA;
                RX_DATA:   if (bit_cnt_reg == 3'd7) state_next = RX_PARITY;
                RX_PARITY: state_next = RX_STOP;
                RX_STOP:   state_next = RX_IDLE;
                default:   state_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_ok   = data_bit && (^{parity_reg, shift_reg});
        valid_next = fall && (state_reg == RX_STOP) && frame_ok;
        err_next   = (fall && (state_reg == RX_STOP) && !frame_ok) || timeout_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg       <= 8'h00;
            bit_cnt_reg     <= 3'd0;
            parity_reg      <= 1'b0;
            timeout_cnt_reg <= '0;
            valid_reg       <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            valid_reg <= valid_next;
            err_reg   <= err_next;

            if (fall) begin
                timeout_cnt_reg <= '0;
            end else if (timeout_cnt_reg != TIMEOUT_MAX) begin
                timeout_cnt_reg <= timeout_cnt_reg + CW'(1);
            end

            if (state_reg == RX_IDLE || timeout_hit) begin
                bit_cnt_reg <= 3'd0;
            end else if (fall && state_reg == RX_DATA) begin
                shift_reg   <= {data_bit, shift_reg[7:1]};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end

            if (fall && state_reg == RX_PARITY) begin
                parity_reg <= data_bit;
            end
        end
    end

    assign rx_byte    = shift_reg;
    assign byte_valid = valid_reg;
    assign frame_err  = err_reg;

endmodule

// File: rtl/ps2_keyboard.sv
// Keyboard front end: turns received set-2 bytes into a held game key
// (lowercase ASCII) plus a press level, tracking break and extended prefixes.
module ps2_keyboard
    import tank_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic       press,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic [7:0] mapped;

    dec_state_t dec_state_reg, dec_state_next;
    logic [7:0] ascii_reg, ascii_next;
    logic       press_reg, press_next;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign mapped = scan_to_ascii(rx_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_state_reg <= DEC_NORM;
        end else begin
            dec_state_reg <= dec_state_next;
        end
    end

    // Corrupt frames never raise byte_valid, so a pending prefix survives them.
    always_comb begin
        dec_state_next = dec_state_reg;
        if (byte_valid) begin
            case (dec_state_reg)
                DEC_NORM: begin
                    if (rx_byte == SC_EXT)        dec_state_next = DEC_EXT;
                    else if (rx_byte == SC_BREAK) dec_state_next = DEC_BRK;
                end
                DEC_BRK:     dec_state_next = DEC_NORM;
                DEC_EXT:     dec_state_next = (rx_byte == SC_BREAK) ? DEC_EXT_BRK : DEC_NORM;
                DEC_EXT_BRK: dec_state_next = DEC_NORM;
                default:     dec_state_next = DEC_NORM;
            endcase
        end
    end

    always_comb begin
        ascii_next = ascii_reg;
        press_next = press_reg;
        if (byte_valid) begin
            case (dec_state_reg)
                DEC_NORM: begin
                    if (mapped != ASCII_NONE) begin
                        ascii_next = mapped;
                        press_next = 1'b1;
                    end
                end
                DEC_BRK: begin
                    // Releasing a key other than the one shown leaves it held.
                    if (mapped != ASCII_NONE && mapped == ascii_reg) begin
                        press_next = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ascii_reg <= ASCII_NONE;
            press_reg <= 1'b0;
        end else begin
            ascii_reg <= ascii_next;
            press_reg <= press_next;
        end
    end

    assign ascii = ascii_reg;
    assign press = press_reg;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: bit-bangs PS/2 frames and checks the held
// key, press level and error pulses against a queue of expected results.
module tb_ps2_keyboard;

    localparam int TO = 200;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ascii;
    logic       press;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;

    typedef struct {
        logic [7:0] ascii;
        logic       press;
        int         errs;
        string      tag;
    } exp_t;

    exp_t sb[$];

    ps2_keyboard #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ascii    (ascii),
        .press    (press),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_bit(input logic b);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Sends one full frame; outputs are checked exactly 4 clk after the stop edge.
    task automatic send_frame(input string tag, input logic [7:0] code, input bit bad_par,
                              input bit bad_stop, input logic [7:0] exp_ascii,
                              input bit exp_press, input int exp_errs, input bit chk_early);
        exp_t e;
        exp_t got;
        int   base;
        e.ascii = exp_ascii;
        e.press = exp_press;
        e.errs  = exp_errs;
        e.tag   = tag;
        sb.push_back(e);
        base = err_seen;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(code[i]);
        drive_bit((~^code) ^ bad_par);
        ps2_data = !bad_stop;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (chk_early) check({tag, "_early_press"}, press, 0);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, "_ascii"}, ascii, got.ascii);
        check({got.tag, "_press"}, press, got.press);
        @(negedge clk);
        repeat (4) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (8) @(negedge clk);
        check({got.tag, "_errs"}, err_seen - base, got.errs);
        $display("frame %s code=%02h ascii=%02h press=%0d errs=%0d",
                 got.tag, code, ascii, press, err_seen - base);
    endtask

    initial begin
        int base;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_ascii", ascii, 8'h00);
        check("reset_press", press, 0);
        check("reset_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame("make_w",       8'h1D, 0, 0, 8'h77, 1, 0, 1);
        send_frame("brk_pfx_w",    8'hF0, 0, 0, 8'h77, 1, 0, 0);
        send_frame("brk_w",        8'h1D, 0, 0, 8'h77, 0, 0, 0);

        send_frame("make_a",       8'h1C, 0, 0, 8'h61, 1, 0, 0);
        send_frame("make_d",       8'h23, 0, 0, 8'h64, 1, 0, 0);
        send_frame("brk_pfx_a",    8'hF0, 0, 0, 8'h64, 1, 0, 0);
        send_frame("brk_a_other",  8'h1C, 0, 0, 8'h64, 1, 0, 0);
        send_frame("brk_pfx_d",    8'hF0, 0, 0, 8'h64, 1, 0, 0);
        send_frame("brk_d",        8'h23, 0, 0, 8'h64, 0, 0, 0);

        send_frame("bad_par_j",    8'h3B, 1, 0, 8'h64, 0, 1, 0);
        send_frame("make_j",       8'h3B, 0, 0, 8'h6A, 1, 0, 0);

        send_frame("ext_pfx",      8'hE0, 0, 0, 8'h6A, 1, 0, 0);
        send_frame("ext_w",        8'h1D, 0, 0, 8'h6A, 1, 0, 0);
        send_frame("ext_pfx2",     8'hE0, 0, 0, 8'h6A, 1, 0, 0);
        send_frame("ext_brk_pfx",  8'hF0, 0, 0, 8'h6A, 1, 0, 0);
        send_frame("ext_brk_w",    8'h1D, 0, 0, 8'h6A, 1, 0, 0);
        send_frame("make_s",       8'h1B, 0, 0, 8'h73, 1, 0, 0);
        send_frame("repeat_s",     8'h1B, 0, 0, 8'h73, 1, 0, 0);
        send_frame("bad_stop_a",   8'h1C, 0, 1, 8'h73, 1, 1, 0);

        // Partial frame: start bit plus 5 data bits, then silence.
        base = err_seen;
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TO - 30) @(negedge clk);
        check("timeout_early", err_seen - base, 0);
        repeat (60) @(negedge clk);
        check("timeout_err", err_seen - base, 1);
        $display("frame timeout_partial errs=%0d", err_seen - base);
        send_frame("after_to_d",   8'h23, 0, 0, 8'h64, 1, 0, 0);

        send_frame("brk_pfx_pend", 8'hF0, 0, 0, 8'h64, 1, 0, 0);
        send_frame("bad_par_mid",  8'h1B, 1, 0, 8'h64, 1, 1, 0);
        send_frame("brk_d_pend",   8'h23, 0, 0, 8'h64, 0, 0, 0);
        send_frame("make_w2",      8'h1D, 0, 0, 8'h77, 1, 0, 0);

        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_press", press, 0);
        check("midrst_ascii", ascii, 8'h00);
        $display("frame mid_reset ascii=%02h press=%0d", ascii, press);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame("post_rst_a",   8'h1C, 0, 0, 8'h61, 1, 0, 0);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard front end that feeds the tank direction/shoot decoder. Receives scan-code set 2 frames from the keyboard pins, tracks make/break/extended prefixes, and presents the held game key as a lowercase ASCII code plus a `press` level. `press` stays high while the key is held, so the decoder keeps `moving`/`shoot` asserted for the whole key-down interval.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 200000: `clk` cycles without a `ps2_clk` falling edge before a partial frame is discarded (2 ms at 100 MHz).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw keyboard clock; asynchronous to `clk`.
- `ps2_data`  in  1  raw keyboard data; asynchronous to `clk`.
- `ascii`  out  8  ASCII code of the currently held game key; 8'h00 when no key has been registered.
- `press`  out  1  high while the key in `ascii` is held.
- `frame_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- Synchronizer: `ps2_clk` and `ps2_data` each pass through 2 flip-flops. A third `ps2_clk` stage gives falling-edge detection (`sync2 == 0 && sync3 == 1`). Data is sampled on the detected edge.
- Receiver FSM has four states:
  - IDLE: a falling edge with data 0 (start bit) goes to DATA. Data 1 stays in IDLE with no error.
  - DATA: shifts 8 bits, LSB first, using a 3-bit counter, then goes to PARITY.
  - PARITY: captures the parity bit, then goes to STOP.
  - STOP: on the next edge, checks data == 1 and odd parity over the 9 bits. On pass, emits `byte_valid` for 1 cycle. On fail, pulses `frame_err` and drops the byte. Returns to IDLE either way.
- Timeout: an edge counter clears on every falling edge. If it reaches `TIMEOUT_CYCLES` outside IDLE, the receiver returns to IDLE and pulses `frame_err`. The counter saturates and does not wrap.
- Decoder FSM acts on `byte_valid` and has four states:
  - NORM:
    - E0 goes to EXT.
    - F0 goes to BRK.
    - A mapped make code sets `ascii` to the mapped value and `press` to 1, so the last key pressed wins.
    - An unmapped make code is ignored.
  - BRK: a byte equal to the scan code of the current `ascii` clears `press`; `ascii` holds its value. Any other byte is ignored. Returns to NORM.
  - EXT: F0 goes to EXT_BRK. Any other byte is ignored and returns to NORM, because extended keys are never mapped.
  - EXT_BRK: the byte is ignored. Returns to NORM.
- Key map (set 2 code to ASCII): 1C→61 'a', 23→64 'd', 1D→77 'w', 1B→73 's', 3B→6A 'j'.
- Auto-repeat make codes for the held key rewrite the same `ascii` and keep `press` at 1. No glitch is allowed.
- A frame error does not change decoder state. A prefix (F0 or E0) stays pending until the next good byte.

## Timing
- Reset values: `ascii` = 8'h00, `press` = 0, `frame_err` = 0. Both FSMs go to IDLE/NORM, and the shift register, bit counter and timeout counter all clear. Reset mid-frame abandons the frame.
- Latency: `ascii`/`press` update exactly 4 `clk` cycles after the `ps2_clk` falling edge that carries the stop bit. The 4 cycles are 2 sync stages, 1 edge/`byte_valid` register and 1 output register.
- `frame_err` asserts on the same cycle that a good frame would have asserted `byte_valid`. On timeout it asserts the cycle after the counter reaches `TIMEOUT_CYCLES`.
- `ascii` and `press` are registered outputs and change only on decoder events.
- Requirement: the `clk` period must be at most 1/4 of the minimum PS/2 clock low time.

## Structure
- Shared package `tank_pkg` holds:
  - scan-code constants `SC_A`, `SC_D`, `SC_W`, `SC_S`, `SC_J`, `SC_BREAK` (F0), `SC_EXT` (E0);
  - the ASCII key constants also used by the direction decoder;
  - the decoder state enum.
- One sub-module, `ps2_rx`. It contains the synchronizer, edge detect, receiver FSM and timeout, and outputs `rx_byte[7:0]`, `byte_valid` and `frame_err`. The top level contains the decoder FSM and key map.

## Test plan
- Make 1D: `ascii` = 8'h77 and `press` = 1, 4 clk after the stop edge. Then F0 1D: `press` = 0 and `ascii` stays 8'h77.
- Make 1C, then make 23 (hold both), then F0 1C: `ascii` = 8'h64 and `press` = 1 (the break of a non-current key is ignored). Then F0 23: `press` = 0.
- Frame with 3B and bad parity: `frame_err` pulses once and `ascii`/`press` are unchanged. Then a good 3B: `ascii` = 8'h6A and `press` = 1.
- E0 1D (extended) then E0 F0 1D: no output change and no error. Then a plain 1B: `ascii` = 8'h73.
- Stop after 5 data bits for `TIMEOUT_CYCLES` + 1 cycles: `frame_err` pulses and the receiver returns to IDLE. The next full 23 frame decodes to 8'h64.
- Assert `rst_n` = 0 mid-frame while `press` = 1: `press` = 0 and `ascii` = 8'h00 immediately. After release, a clean 1C decodes to 8'h61.
